// File: rtl/bcd_step_counter.sv
// bcd_step_counter: steps one BCD digit 0..LIMIT at a fixed dwell rate.
// Optional down counting via `BCD_STEP_DOWN_EN (adds the up_dn port).
module bcd_step_counter #(
  parameter int START = 0,
  parameter int LIMIT = 9,
  parameter int DWELL = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       stop,
  input  logic       oneshot,
  input  logic       load,
  input  logic [3:0] load_val,
`ifdef BCD_STEP_DOWN_EN
  input  logic       up_dn,
`endif
  output logic [3:0] c,
  output logic       carry,
  output logic       err,
  output logic       busy
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [3:0] LIM  = 4'(LIMIT);
  localparam logic [3:0] INIT = 4'(START);
  localparam logic [7:0] LAST = 8'(DWELL - 1);

  state_t     state;
  state_t     state_nx;
  logic [7:0] pre;
  logic [7:0] pre_nx;
  logic [3:0] c_nx;
  logic       carry_nx;
  logic       err_nx;

  logic dir;
  logic load_ok;
  logic ld_take;
  logic at_last;
  logic step;
  logic wrap;

`ifdef BCD_STEP_DOWN_EN
  assign dir = up_dn;
`else
  assign dir = 1'b1;
`endif

  assign load_ok = (load_val <= LIM);
  assign ld_take = load & load_ok;
  assign at_last = (pre == LAST);
  assign step    = (state == RUN) & ~load
                 & ~stop & at_last;
  assign wrap    = dir ? (c == LIM)
                       : (c == 4'd0);
  assign busy    = (state == RUN);

  // Next FSM state; a load freezes the state for that cycle.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (!load && start && !stop)
          state_nx = RUN;
      end
      RUN: begin
        if (!load && stop)
          state_nx = IDLE;
        else if (step && wrap && oneshot)
          state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Dwell prescaler: free-runs only in RUN, any load restarts it.
  always_comb begin
    pre_nx = pre + 8'd1;
    if (load)
      pre_nx = 8'd0;
    else if (state != RUN)
      pre_nx = 8'd0;
    else if (stop)
      pre_nx = 8'd0;
    else if (at_last)
      pre_nx = 8'd0;
  end

  // Digit update; an accepted load and a step never coincide.
  always_comb begin
    c_nx     = c;
    carry_nx = step & wrap;
    err_nx   = load & ~load_ok;
    unique case (1'b1)
      ld_take: c_nx = load_val;
      step: begin
        if (dir)
          c_nx = wrap ? 4'd0 : c + 4'd1;
        else
          c_nx = wrap ? LIM : c - 4'd1;
      end
      default: c_nx = c;
    endcase
  end

  // State, prescaler and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      pre   <= 8'd0;
      c     <= INIT;
      carry <= 1'b0;
      err   <= 1'b0;
    end else begin
      state <= state_nx;
      pre   <= pre_nx;
      c     <= c_nx;
      carry <= carry_nx;
      err   <= err_nx;
    end
  end

endmodule

// File: tb/tb_bcd_step_counter.sv
// tb_bcd_step_counter: directed scenarios plus random run against
// an edge-scheduled behavioural model, on two parameter sets.
module tb_bcd_step_counter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       oneshot = 1'b0;
  logic       load = 1'b0;
  logic [3:0] load_val = 4'd0;
  logic       up_dn = 1'b1;

  logic [3:0] ca, cb;
  logic carrya, carryb, erra, errb, busya, busyb;

  int checks = 0;
  int errors = 0;

  localparam int LIMS[2] = '{9, 5};
  localparam int DWS[2]  = '{4, 1};

  int ecnt = 0;
  int m_c[2];
  int m_next[2];
  bit m_run[2];
  bit m_carry[2];
  bit m_err[2];

  always #5 clk = ~clk;

  bcd_step_counter #(.START(0), .LIMIT(9), .DWELL(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
    .oneshot(oneshot), .load(load), .load_val(load_val),
`ifdef BCD_STEP_DOWN_EN
    .up_dn(up_dn),
`endif
    .c(ca), .carry(carrya), .err(erra), .busy(busya)
  );

  bcd_step_counter #(.START(0), .LIMIT(5), .DWELL(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
    .oneshot(oneshot), .load(load), .load_val(load_val),
`ifdef BCD_STEP_DOWN_EN
    .up_dn(up_dn),
`endif
    .c(cb), .carry(carryb), .err(errb), .busy(busyb)
  );

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_c[i] = 0;
      m_run[i] = 0;
      m_carry[i] = 0;
      m_err[i] = 0;
      m_next[i] = 0;
    end
  endtask

  // Digit steps on scheduled edge numbers; a load reschedules.
  task automatic model_edge();
    bit up;
`ifdef BCD_STEP_DOWN_EN
    up = up_dn;
`else
    up = 1'b1;
`endif
    for (int i = 0; i < 2; i++) begin
      m_carry[i] = 0;
      m_err[i] = 0;
      if (load) begin
        if (int'(load_val) <= LIMS[i]) m_c[i] = int'(load_val);
        else m_err[i] = 1;
        m_next[i] = ecnt + DWS[i];
      end else if (m_run[i] && stop) begin
        m_run[i] = 0;
      end else if (m_run[i] && ecnt == m_next[i]) begin
        if (up) begin
          m_carry[i] = (m_c[i] == LIMS[i]);
          m_c[i] = m_carry[i] ? 0 : m_c[i] + 1;
        end else begin
          m_carry[i] = (m_c[i] == 0);
          m_c[i] = m_carry[i] ? LIMS[i] : m_c[i] - 1;
        end
        m_next[i] = ecnt + DWS[i];
        if (m_carry[i] && oneshot) m_run[i] = 0;
      end else if (!m_run[i] && start && !stop) begin
        m_run[i] = 1;
        m_next[i] = ecnt + DWS[i];
      end
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    if (rst_n) begin
      ecnt++;
      model_edge();
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    checks++;
    if (ca !== 4'd0) begin
      errors++; $display("FAIL rst_c got %0d exp 0", ca);
    end
    checks++;
    if (busya !== 1'b0 || busyb !== 1'b0) begin
      errors++; $display("FAIL rst_busy got %b%b exp 00", busya, busyb);
    end
    checks++;
    if (carrya !== 1'b0 || erra !== 1'b0) begin
      errors++; $display("FAIL rst_pulse got %b%b exp 00", carrya, erra);
    end
    rst_n = 1'b1;
    repeat (5) cyc();
    checks++;
    if (ca !== 4'd0 || busya !== 1'b0) begin
      errors++; $display("FAIL rst_hold got %0d/%b exp 0/0", ca, busya);
    end
  endtask

  task automatic test_continuous();
    start = 1'b1;
    cyc();
    start = 1'b0;
    checks++;
    if (busya !== 1'b1) begin
      errors++; $display("FAIL cont_busy got %b exp 1", busya);
    end
    for (int e = 1; e <= 41; e++) begin
      cyc();
      checks++;
      if (ca !== 4'((e / 4) % 10)) begin
        errors++;
        $display("FAIL cont_c e=%0d got %0d exp %0d", e, ca, (e / 4) % 10);
      end
      checks++;
      if (carrya !== (e == 40)) begin
        errors++;
        $display("FAIL cont_carry e=%0d got %b exp %b", e, carrya, e == 40);
      end
    end
    stop = 1'b1;
    cyc();
    stop = 1'b0;
    checks++;
    if (busya !== 1'b0 || ca !== 4'd0) begin
      errors++; $display("FAIL cont_stop got %b/%0d exp 0/0", busya, ca);
    end
  endtask

  task automatic test_oneshot();
    load = 1'b1; load_val = 4'd0;
    cyc();
    load = 1'b0;
    oneshot = 1'b1; start = 1'b1;
    cyc();
    start = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      cyc();
      checks++;
      if (cb !== 4'(k % 6)) begin
        errors++; $display("FAIL os_c k=%0d got %0d exp %0d", k, cb, k % 6);
      end
      checks++;
      if (carryb !== (k == 6) || busyb !== (k < 6)) begin
        errors++;
        $display("FAIL os_flags k=%0d got %b%b exp %b%b",
                 k, carryb, busyb, k == 6, k < 6);
      end
    end
    repeat (3) cyc();
    checks++;
    if (cb !== 4'd0 || busyb !== 1'b0 || carryb !== 1'b0) begin
      errors++;
      $display("FAIL os_hold got %0d/%b/%b exp 0/0/0", cb, busyb, carryb);
    end
    oneshot = 1'b0;
    stop = 1'b1;
    cyc();
    stop = 1'b0;
  endtask

  task automatic test_load();
    start = 1'b1;
    cyc();
    start = 1'b0;
    load = 1'b1; load_val = 4'd7;
    cyc();
    load = 1'b0;
    checks++;
    if (ca !== 4'd7 || busya !== 1'b1) begin
      errors++; $display("FAIL ld7 got %0d/%b exp 7/1", ca, busya);
    end
    checks++;
    if (errb !== 1'b1 || cb !== 4'd0) begin
      errors++; $display("FAIL ld7_b got %b/%0d exp 1/0", errb, cb);
    end
    repeat (3) cyc();
    checks++;
    if (ca !== 4'd7) begin
      errors++; $display("FAIL ld7_hold got %0d exp 7", ca);
    end
    cyc();
    checks++;
    if (ca !== 4'd8) begin
      errors++; $display("FAIL ld7_step got %0d exp 8", ca);
    end
    load = 1'b1; load_val = 4'd12;
    cyc();
    load = 1'b0;
    checks++;
    if (ca !== 4'd8 || erra !== 1'b1) begin
      errors++; $display("FAIL ld12 got %0d/%b exp 8/1", ca, erra);
    end
    cyc();
    checks++;
    if (erra !== 1'b0) begin
      errors++; $display("FAIL ld12_pulse got %b exp 0", erra);
    end
  endtask

  task automatic test_simultaneous();
    load = 1'b1; load_val = 4'd9;
    cyc();
    load = 1'b0;
    repeat (3) cyc();
    checks++;
    if (ca !== 4'd9) begin
      errors++; $display("FAIL sim_pre got %0d exp 9", ca);
    end
    load = 1'b1; load_val = 4'd3;
    cyc();
    load = 1'b0;
    checks++;
    if (ca !== 4'd3 || carrya !== 1'b0) begin
      errors++; $display("FAIL sim_ldstep got %0d/%b exp 3/0", ca, carrya);
    end
    repeat (3) cyc();
    stop = 1'b1;
    cyc();
    stop = 1'b0;
    checks++;
    if (ca !== 4'd3 || busya !== 1'b0) begin
      errors++; $display("FAIL sim_stopstep got %0d/%b exp 3/0", ca, busya);
    end
    start = 1'b1; stop = 1'b1;
    cyc();
    start = 1'b0; stop = 1'b0;
    checks++;
    if (busya !== 1'b0 || busyb !== 1'b0) begin
      errors++; $display("FAIL sim_ststp got %b%b exp 00", busya, busyb);
    end
  endtask

`ifdef BCD_STEP_DOWN_EN
  task automatic test_down();
    up_dn = 1'b0;
    load = 1'b1; load_val = 4'd0;
    cyc();
    load = 1'b0;
    start = 1'b1;
    cyc();
    start = 1'b0;
    repeat (4) cyc();
    checks++;
    if (ca !== 4'd9 || carrya !== 1'b1) begin
      errors++; $display("FAIL down_wrap got %0d/%b exp 9/1", ca, carrya);
    end
    cyc();
    checks++;
    if (ca !== 4'd9 || carrya !== 1'b0) begin
      errors++; $display("FAIL down_after got %0d/%b exp 9/0", ca, carrya);
    end
    stop = 1'b1;
    cyc();
    stop = 1'b0;
    up_dn = 1'b1;
  endtask
`endif

  task automatic test_midrun_reset();
    load = 1'b1; load_val = 4'd0;
    cyc();
    load = 1'b0;
    start = 1'b1;
    cyc();
    start = 1'b0;
    repeat (6) cyc();
    checks++;
    if (ca !== 4'd1 || carryb !== 1'b1) begin
      errors++; $display("FAIL mr_pre got %0d/%b exp 1/1", ca, carryb);
    end
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if (ca !== 4'd0 || busya !== 1'b0) begin
      errors++; $display("FAIL mr_a got %0d/%b exp 0/0", ca, busya);
    end
    checks++;
    if (cb !== 4'd0 || busyb !== 1'b0 || carryb !== 1'b0) begin
      errors++;
      $display("FAIL mr_b got %0d/%b/%b exp 0/0/0", cb, busyb, carryb);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_random();
    for (int n = 0; n < 500; n++) begin
      start    = ($urandom_range(0, 3) == 0);
      stop     = ($urandom_range(0, 9) == 0);
      load     = ($urandom_range(0, 9) == 0);
      load_val = 4'($urandom_range(0, 15));
      oneshot  = ($urandom_range(0, 3) == 0);
`ifdef BCD_STEP_DOWN_EN
      up_dn    = 1'($urandom_range(0, 1));
`endif
      cyc();
      checks++;
      if (ca !== 4'(m_c[0]) || cb !== 4'(m_c[1])) begin
        errors++;
        $display("FAIL rnd_c n=%0d got %0d/%0d exp %0d/%0d",
                 n, ca, cb, m_c[0], m_c[1]);
      end
      checks++;
      if (busya !== m_run[0] || busyb !== m_run[1]) begin
        errors++;
        $display("FAIL rnd_busy n=%0d got %b%b exp %b%b",
                 n, busya, busyb, m_run[0], m_run[1]);
      end
      checks++;
      if (carrya !== m_carry[0] || carryb !== m_carry[1]) begin
        errors++;
        $display("FAIL rnd_carry n=%0d got %b%b exp %b%b",
                 n, carrya, carryb, m_carry[0], m_carry[1]);
      end
      checks++;
      if (erra !== m_err[0] || errb !== m_err[1]) begin
        errors++;
        $display("FAIL rnd_err n=%0d got %b%b exp %b%b",
                 n, erra, errb, m_err[0], m_err[1]);
      end
    end
    start = 1'b0; stop = 1'b0; load = 1'b0; oneshot = 1'b0;
  endtask

  initial begin
    test_reset();
    test_continuous();
    test_oneshot();
    test_load();
    test_simultaneous();
`ifdef BCD_STEP_DOWN_EN
    test_down();
`endif
    test_midrun_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
